// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared types, constants and helpers for the 4-way round-robin arbiter
package rr_arb4_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int NREQ = 4;
    localparam int HOLD_MAX = 7;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;
    function automatic logic [PTR_W-1:0] oh2idx(input logic [NREQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/rr_arb4_prio.sv
// rr_arb4_prio: rotating priority encoder, first set request at or after ptr wins
module rr_arb4_prio
    import rr_arb4_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  sel,
    output logic             valid
);
    // scan from farthest to nearest offset so the nearest request wins
    always_comb begin
        sel = '0;
        valid = |req;
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[ptr + PTR_W'(j)]) sel = NREQ'(1) << (ptr + PTR_W'(j));
    end
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way locking round-robin arbiter; define RR_ARB4_TIMEOUT_EN for the 8-cycle hold timeout
module rr_arb4
    import rr_arb4_pkg::*;
(
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    output logic             q0,
    output logic             q1,
    output logic             q2,
    output logic             q3,
    output logic             nq,
    output logic [PTR_W-1:0] ptr
);
    state_t state;
    logic [NREQ-1:0] req, q, q_nxt, sel;
    logic [PTR_W-1:0] ptr_nxt;
    logic valid, held, timeout, keep, take;
    assign req = {i3, i2, i1, i0};
    assign {q3, q2, q1, q0} = q;
    assign held = |(q & req);
    rr_arb4_prio u_prio (
        .req  (req & ~q),
        .ptr  (ptr),
        .sel  (sel),
        .valid(valid)
    );
`ifdef RR_ARB4_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    assign timeout = (cnt == CNT_W'(HOLD_MAX)) && valid;
`else
    assign timeout = 1'b0;
`endif
    // hold a live grant unless it timed out; otherwise arbitrate among the others
    always_comb begin
        keep = (state == GRANT) && held && !timeout;
        take = en && valid && !keep;
        q_nxt = take ? sel : keep ? q : '0;
        ptr_nxt = take ? oh2idx(sel) + 1'b1 : ptr;
    end
    // registered state, grants, idle flag, pointer and hold counter
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            nq <= 1'b1;
            ptr <= '0;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt <= '0;
`endif
        end else begin
            state <= |q_nxt ? GRANT : IDLE;
            q <= q_nxt;
            nq <= ~|q_nxt;
            ptr <= ptr_nxt;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt <= !keep ? '0 : (cnt == CNT_W'(HOLD_MAX)) ? cnt : cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed self-checking bench for rr_arb4
module tb_rr_arb4;
    logic ck = 1'b0, rst = 1'b1, en = 1'b0;
    logic [3:0] i = '0;
    logic q0, q1, q2, q3, nq;
    logic [1:0] ptr;
    logic [3:0] q;
    int checks = 0, errors = 0;
    assign q = {q3, q2, q1, q0};

    rr_arb4 dut (
        .ck (ck),
        .rst(rst),
        .en (en),
        .i0 (i[0]),
        .i1 (i[1]),
        .i2 (i[2]),
        .i3 (i[3]),
        .q0 (q0),
        .q1 (q1),
        .q2 (q2),
        .q3 (q3),
        .nq (nq),
        .ptr(ptr)
    );

    always #5 ck = ~ck;

    task automatic tick;
        @(posedge ck);
        #1;
        checks++;
        if ($countones(q) > 1 || nq !== ~|q) begin
            errors++;
            $display("FAIL invariant: q=%b nq=%b, need one-hot q and nq=~|q", q, nq);
        end
    endtask

    task automatic do_reset;
        i = '0;
        en = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b1;
        i = 4'b0100;
        @(posedge ck);
        #1;
        checks++;
        if ({q, nq, ptr} !== {4'b0000, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: q=%b nq=%b ptr=%0d, need q=0000 nq=1 ptr=0", q, nq, ptr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({q, nq} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL release_no_grant: q=%b nq=%b, need q=0000 nq=1", q, nq);
        end
        tick();
        checks++;
        if ({q, nq, ptr} !== {4'b0100, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL first_grant: q=%b nq=%b ptr=%0d, need q=0100 nq=0 ptr=3", q, nq, ptr);
        end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_p [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        en = 1'b1;
        i = 4'b1111;
        tick();
        checks++;
        if ({q, ptr} !== {4'b0001, 2'd1}) begin
            errors++;
            $display("FAIL rotation_0: q=%b ptr=%0d, need q=0001 ptr=1", q, ptr);
        end
        for (int k = 0; k < 4; k++) begin
            i = 4'b1111 & ~q;
            tick();
            checks++;
            if ({q, ptr} !== {exp_q[k], exp_p[k]}) begin
                errors++;
                $display("FAIL rotation_%0d: q=%b ptr=%0d, need q=%b ptr=%0d", k + 1, q, ptr, exp_q[k], exp_p[k]);
            end
        end
    endtask

    task automatic test_hold;
        do_reset();
        en = 1'b1;
        i = 4'b0010;
        tick();
        checks++;
        if ({q, ptr} !== {4'b0010, 2'd2}) begin
            errors++;
            $display("FAIL hold_grant: q=%b ptr=%0d, need q=0010 ptr=2", q, ptr);
        end
        i = 4'b1010;
`ifdef RR_ARB4_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (q !== 4'b0010) begin
                errors++;
                $display("FAIL hold_pre_timeout_%0d: q=%b, need 0010", k, q);
            end
        end
        tick();
        checks++;
        if ({q, ptr} !== {4'b1000, 2'd0}) begin
            errors++;
            $display("FAIL timeout_revoke: q=%b ptr=%0d, need q=1000 ptr=0", q, ptr);
        end
        i = 4'b1000;
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if ({q, ptr} !== {4'b1000, 2'd0}) begin
            errors++;
            $display("FAIL timeout_saturate: q=%b ptr=%0d, need q=1000 ptr=0", q, ptr);
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({q, ptr} !== {4'b0010, 2'd2}) begin
                errors++;
                $display("FAIL hold_locked_%0d: q=%b ptr=%0d, need q=0010 ptr=2", k, q, ptr);
            end
        end
        i = 4'b1000;
        tick();
        checks++;
        if ({q, nq, ptr} !== {4'b1000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL hold_handoff: q=%b nq=%b ptr=%0d, need q=1000 nq=0 ptr=0", q, nq, ptr);
        end
`endif
    endtask

    task automatic test_enable;
        do_reset();
        en = 1'b0;
        i = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({nq, ptr} !== {1'b1, 2'd0}) begin
                errors++;
                $display("FAIL en_low_idle_%0d: nq=%b ptr=%0d, need nq=1 ptr=0", k, nq, ptr);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({q, ptr} !== {4'b0010, 2'd2}) begin
            errors++;
            $display("FAIL en_rise_grant: q=%b ptr=%0d, need q=0010 ptr=2", q, ptr);
        end
        en = 1'b0;
        i = 4'b0110;
        tick();
        checks++;
        if (q !== 4'b0010) begin
            errors++;
            $display("FAIL en_low_locked: q=%b, need 0010", q);
        end
        i = 4'b0100;
        tick();
        checks++;
        if ({q, nq, ptr} !== {4'b0000, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL en_low_release: q=%b nq=%b ptr=%0d, need q=0000 nq=1 ptr=2", q, nq, ptr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        en = 1'b1;
        i = 4'b0100;
        tick();
        checks++;
        if (q !== 4'b0100) begin
            errors++;
            $display("FAIL mid_setup: q=%b, need 0100", q);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({q, nq, ptr} !== {4'b0000, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_async: q=%b nq=%b ptr=%0d, need q=0000 nq=1 ptr=0", q, nq, ptr);
        end
        rst = 1'b0;
        i = 4'b1111;
        tick();
        checks++;
        if ({q, ptr} !== {4'b0001, 2'd1}) begin
            errors++;
            $display("FAIL mid_restart: q=%b ptr=%0d, need q=0001 ptr=1", q, ptr);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
